// File: rtl/full_adder_pkg.sv
// Shared constants, types and the reference sum model for the full_adder block.
package full_adder_pkg;

    localparam int unsigned DefaultWidth = 1;
    localparam int unsigned DefaultCntW  = 16;
    localparam int unsigned RefMaxW      = 64;

    typedef logic [DefaultCntW-1:0] carry_cnt_t;

    // Returns {cout, sum} for a w-bit add; operands are truncated to w bits first.
    function automatic logic [RefMaxW:0] ref_add(input logic [RefMaxW-1:0] a,
                                                 input logic [RefMaxW-1:0] b,
                                                 input logic               cin,
                                                 input int unsigned        w);
        logic [RefMaxW:0] op_mask;
        logic [RefMaxW:0] res_mask;
        logic [RefMaxW:0] r;
        op_mask  = (({{RefMaxW{1'b0}}, 1'b1}) << w) - 1'b1;
        res_mask = (op_mask << 1) | 1'b1;
        r = ({1'b0, a} & op_mask) + ({1'b0, b} & op_mask) + {{RefMaxW{1'b0}}, cin};
        return r & res_mask;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder cell: sum and majority carry.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH cells with a valid-qualified result register.
// Optional carry-event counter enabled by FULL_ADDER_STATS_EN.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    input  logic             in_valid,
    output logic             out_valid,
    output logic [WIDTH-1:0] S_q,
    output logic             Cout_q,
    output logic [CNT_W-1:0] carry_count
);

    logic [WIDTH:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a_i  (A[i]),
            .b_i  (B[i]),
            .c_i  (carry[i]),
            .s_o  (S[i]),
            .co_o (carry[i+1])
        );
    end

    assign Cout = carry[WIDTH];

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // Unknown in_valid falls through to the hold branch in simulation.
    always_comb begin
        valid_d = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (in_valid) begin
            valid_d = 1'b1;
            sum_d   = S;
            cout_d  = Cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign out_valid = valid_q;
    assign S_q       = sum_q;
    assign Cout_q    = cout_q;

`ifdef FULL_ADDER_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && Cout && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_count = cnt_q;
`else
    assign carry_count = '0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed and random bench for full_adder at WIDTH 1, 8 and 16.
module tb_full_adder;
    import full_adder_pkg::*;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst = 1'b0;

    always #5 if (clk_run) clk = ~clk;

    // WIDTH=1 instance, small counter for saturation
    logic a1, b1, c1, s1, co1, v1, ov1, sq1, coq1;
    logic [1:0] cnt1;
    // WIDTH=8 instance
    logic [7:0] a8, b8, s8, sq8;
    logic c8, co8, ov8, coq8;
    logic [15:0] cnt8;
    // WIDTH=16 instance
    logic [15:0] a16, b16, s16, sq16;
    logic c16, co16, v16, ov16, coq16;
    logic [15:0] cnt16;

    full_adder #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .S(s1), .Cout(co1),
        .in_valid(v1), .out_valid(ov1), .S_q(sq1), .Cout_q(coq1), .carry_count(cnt1)
    );

    full_adder #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .S(s8), .Cout(co8),
        .in_valid(1'b0), .out_valid(ov8), .S_q(sq8), .Cout_q(coq8), .carry_count(cnt8)
    );

    full_adder #(.WIDTH(16), .CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(c16), .S(s16), .Cout(co16),
        .in_valid(v16), .out_valid(ov16), .S_q(sq16), .Cout_q(coq16), .carry_count(cnt16)
    );

    logic [1:0]  sb1[$];
    logic [16:0] sb16[$];
    logic        last_sq1;
    logic        last_coq1;
    logic [1:0]  exp_cnt;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One registered-path step on dut1: drive at negedge, check after the edge.
    task automatic step1(input logic a, input logic b, input logic c, input logic v);
        logic [64:0] r;
        logic [1:0]  e;
        @(negedge clk);
        a1 = a; b1 = b; c1 = c; v1 = v;
        r = ref_add(64'(a), 64'(b), c, 1);
        if (v) begin
            sb1.push_back(r[1:0]);
`ifdef FULL_ADDER_STATS_EN
            if (r[1] && exp_cnt != 2'b11) exp_cnt = exp_cnt + 2'd1;
`endif
        end
        @(posedge clk);
        #1;
        if (v) begin
            check("reg1_valid", 65'(ov1), 65'd1);
            if (sb1.size() == 0) begin
                check("reg1_sb_empty", 65'd1, 65'd0);
            end else begin
                e = sb1.pop_front();
                check("reg1_sum", 65'({coq1, sq1}), 65'(e));
                last_sq1 = e[0];
                last_coq1 = e[1];
            end
        end else begin
            check("reg1_valid_low", 65'(ov1), 65'd0);
            check("reg1_hold", 65'({coq1, sq1}), 65'({last_coq1, last_sq1}));
        end
        check("reg1_cnt", 65'(cnt1), 65'(exp_cnt));
    endtask

    initial begin
        logic [2:0]  tt_in[8];
        logic [1:0]  tt_out[8];
        logic [64:0] r;
        logic [16:0] e16;

        a1 = 0; b1 = 0; c1 = 0; v1 = 0;
        a8 = 0; b8 = 0; c8 = 0;
        a16 = 0; b16 = 0; c16 = 0; v16 = 0;
        exp_cnt = 2'd0; last_sq1 = 1'b0; last_coq1 = 1'b0;

        // {A,B,Cin} -> {Cout,S}, no clock running
        tt_in  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
        tt_out = '{2'b00,  2'b01,  2'b01,  2'b10,  2'b01,  2'b10,  2'b10,  2'b11};
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = tt_in[i];
            #5;
            check($sformatf("tt_%0d", i), 65'({co1, s1}), 65'(tt_out[i]));
            #5;
        end

        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        #5 check("ripple_ff", 65'({co8, s8}), 65'h100);
        #5 a8 = 8'h5A; b8 = 8'hA5; c8 = 1'b0;
        #5 check("ripple_5a", 65'({co8, s8}), 65'h0FF);
        #5;

        clk_run = 1'b1;
        a1 = 0; b1 = 0; c1 = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 65'(ov1), 65'd0);
        check("rst_sq", 65'({coq1, sq1}), 65'd0);
        check("rst_cnt", 65'(cnt1), 65'd0);
        check("rst_valid16", 65'(ov16), 65'd0);
        @(negedge clk);
        rst = 1'b0;

        step1(1, 1, 1, 1);
        step1(0, 0, 0, 0);
        step1(1, 0, 0, 1);
        step1(1, 1, 0, 1);
        step1(1, 0, 1, 1);
        step1(0, 1, 1, 1);
        step1(1, 1, 1, 1);
        step1(0, 0, 0, 0);
`ifdef FULL_ADDER_STATS_EN
        check("cnt_saturated", 65'(cnt1), 65'd3);
`else
        check("cnt_tied_zero", 65'(cnt1), 65'd0);
`endif

        // Reset wins over a valid operation in the same cycle.
        @(negedge clk);
        rst = 1'b1; v1 = 1'b1; a1 = 1; b1 = 1; c1 = 1;
        @(posedge clk);
        #1;
        check("midrst_valid", 65'(ov1), 65'd0);
        check("midrst_sq", 65'({coq1, sq1}), 65'd0);
        check("midrst_cnt", 65'(cnt1), 65'd0);
        @(negedge clk);
        rst = 1'b0; v1 = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            v16 = 1'b1;
            r = ref_add(64'(a16), 64'(b16), c16, 16);
            #1;
            check("rand_comb", 65'({co16, s16}), r);
            sb16.push_back(r[16:0]);
            @(posedge clk);
            #1;
            if (sb16.size() == 0) begin
                check("rand_sb_empty", 65'd1, 65'd0);
            end else begin
                e16 = sb16.pop_front();
                check("rand_reg", 65'({ov16, coq16, sq16}), 65'({1'b1, e16}));
            end
        end
        @(negedge clk);
        v16 = 1'b0;
        @(posedge clk);
        #1;
        check("rand_valid_drop", 65'(ov16), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_adder.md
# full_adder

Full adder with combinational sum/carry outputs and a registered, valid-qualified result stage. The default 1-bit configuration is the textbook single-bit full adder, which is the basic arithmetic cell in the chapter's adder examples. A WIDTH parameter turns it into a ripple-carry adder built from the same single-bit cell. The combinational path works with no clock activity; the registered path serves pipelined callers.

## Interface
- WIDTH, 1, operand width in bits (≥1).
- CNT_W, 16, width of the carry-event counter.

- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry in to bit 0.
- S  output  WIDTH  combinational sum, A+B+Cin modulo 2^WIDTH.
- Cout  output  1  combinational carry out of the MSB.
- in_valid  input  1  qualifies A/B/Cin for the registered stage.
- out_valid  output  1  registered valid.
- S_q  output  WIDTH  registered sum.
- Cout_q  output  1  registered carry out.
- carry_count  output  CNT_W  count of accepted operations with Cout=1.

## Operation
- Per-bit cell: s = a^b^c; co = (a&b)|(a&c)|(b&c).
- Ripple chain: bit 0 carry-in is Cin; bit i carry-in is bit i-1 carry-out. Cout is the carry-out of bit WIDTH-1.
- {Cout,S} == A+B+Cin exactly; result width is WIDTH+1. No overflow flag.
- S and Cout are purely combinational:
  - They depend on no clock, reset or in_valid.
  - They must be correct with clk/rst unconnected.
- Registered stage, each rising clk:
  - rst=1: out_valid←0, S_q←0, Cout_q←0, carry_count←0.
  - rst=0, in_valid=1: S_q←S, Cout_q←Cout, out_valid←1.
  - rst=0, in_valid=0: out_valid←0; S_q and Cout_q hold their last values.
- X/Z on in_valid is treated as 0 for register updates.
- carry_count (stats feature only):
  - Increments on each accepted operation (rst=0, in_valid=1) whose Cout=1.
  - Saturates at 2^CNT_W−1.
- Reset mid-stream overrides in_valid; the operation presented in that cycle is dropped.

## Timing
- Combinational path: zero-cycle latency; S/Cout settle within the same delta/propagation window as input changes.
- Registered path: 1-cycle latency, in_valid at edge n → out_valid, S_q, Cout_q visible after edge n.
- Throughput: one operation per cycle, no backpressure, no stalls.
- All outputs after reset: out_valid=0, S_q=0, Cout_q=0, carry_count=0.
- carry_count updates on the same edge as S_q.

## Configuration
- Macro: FULL_ADDER_STATS_EN.
- Defined: carry_count counter implemented as specified.
- Not defined: the counter is omitted and carry_count is tied to 0. All other behaviour is identical.

## Structure
- Shared package full_adder_pkg holds:
  - default WIDTH and CNT_W constants;
  - typedef carry_cnt_t (logic [CNT_W-1:0]);
  - a function ref_add(a,b,cin) returning the WIDTH+1-bit reference sum, used by benches.
- One sub-module, full_adder_cell: single-bit a, b, c → s, co. The top instantiates WIDTH cells in a generate loop.

## Test plan
- Exhaustive 1-bit truth table, WIDTH=1, inputs stepped every 10 ns with no clock:
  - {A,B,Cin}=000→S=0,Cout=0
  - 010→1,0
  - 100→1,0
  - 110→0,1
  - 001→1,0
  - 011→0,1
  - 101→0,1
  - 111→1,1
- Ripple chain, WIDTH=8:
  - A=8'hFF, B=8'h00, Cin=1 → S=8'h00, Cout=1.
  - A=8'h5A, B=8'hA5, Cin=0 → S=8'hFF, Cout=0.
- Registered path: rst 2 cycles, then in_valid=1 with A=1,B=1,Cin=1 (WIDTH=1) → next cycle out_valid=1, S_q=1, Cout_q=1. in_valid=0 next → out_valid=0, S_q holds 1.
- Reset mid-stream: rst=1 together with in_valid=1 → after the edge out_valid=0, S_q=0, Cout_q=0, carry_count=0.
- Stats, with FULL_ADDER_STATS_EN, CNT_W=2: five accepted carry-producing operations → carry_count=3 (saturated). Without the macro, carry_count stays 0.
- Random compare of {Cout,S} against ref_add for 1000 vectors, WIDTH=16 → zero mismatches.
